// File: rtl/muldiv_unit_if.sv
// Operand/strobe bus between the E-stage decoder and the multiply/divide unit.
// Handshake: an op strobe is the valid, ~busy is the ready; an op transfers only on an
// edge where its strobe is high, kill is low and busy is low. Otherwise it is dropped,
// not held.
interface muldiv_unit_if;
    logic        mult;
    logic        multu;
    logic        div;
    logic        divu;
    logic        mthi;
    logic        mtlo;
    logic        kill;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output mult, multu, div, divu, mthi, mtlo, kill, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  mult, multu, div, divu, mthi, mtlo, kill, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Fixed-latency multiply/divide unit holding the architectural HI/LO registers.
// Results are computed at issue, parked in pending regs and committed when the counter expires.
module muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic               clk,
    input  logic               reset,
    muldiv_unit_if.slave       bus,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    logic        busy_w;
    logic        go;
    logic        do_mult;
    logic        do_multu;
    logic        do_div;
    logic        do_divu;
    logic        do_mthi;
    logic        do_mtlo;
    logic        finish;

    // Issue gating and fixed strobe priority.
    always_comb begin
        busy_w   = (state != IDLE);
        go       = ~bus.kill & ~busy_w;
        do_mult  = go & bus.mult;
        do_multu = go & ~bus.mult & bus.multu;
        do_div   = go & ~bus.mult & ~bus.multu & bus.div;
        do_divu  = go & ~bus.mult & ~bus.multu & ~bus.div & bus.divu;
        do_mthi  = go & ~bus.mult & ~bus.multu & ~bus.div & ~bus.divu & bus.mthi;
        do_mtlo  = go & ~bus.mult & ~bus.multu & ~bus.div & ~bus.divu & ~bus.mthi & bus.mtlo;
        finish   = busy_w & (cnt == 4'd1);
    end

    // Multiplier: the low 64 bits of a product of sign-extended operands is the signed product.
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;

    always_comb begin
        mul_a   = do_mult ? {{32{bus.a[31]}}, bus.a} : {32'd0, bus.a};
        mul_b   = do_mult ? {{32{bus.b[31]}}, bus.b} : {32'd0, bus.b};
        product = mul_a * mul_b;
    end

    // Divider works on magnitudes; signs are reapplied so the quotient truncates toward zero
    // and the remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000 rem 0.
    logic        div_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    always_comb begin
        div_signed = do_div;
        a_neg      = div_signed & bus.a[31];
        b_neg      = div_signed & bus.b[31];
        a_mag      = a_neg ? (~bus.a + 32'd1) : bus.a;
        b_mag      = b_neg ? (~bus.b + 32'd1) : bus.b;
        b_safe     = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag      = a_mag / b_safe;
        r_mag      = a_mag % b_safe;
        quot       = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem        = a_neg ? (~r_mag + 32'd1) : r_mag;
        if (bus.b == 32'd0) begin
            quot = 32'hFFFF_FFFF;
            rem  = bus.a;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (do_mult | do_multu) begin
                    state_nxt = MUL;
                end else if (do_div | do_divu) begin
                    state_nxt = DIV;
                end
            end
            MUL, DIV: begin
                if (cnt == 4'd1) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counter, pending results, HI/LO and the completion pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= 4'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            done_q <= finish;
            if (busy_w) begin
                cnt <= cnt - 4'd1;
                if (finish) begin
                    hi_q <= pend_hi;
                    lo_q <= pend_lo;
                end
            end else if (do_mult | do_multu) begin
                cnt     <= 4'(MULT_CYCLES);
                pend_hi <= product[63:32];
                pend_lo <= product[31:0];
            end else if (do_div | do_divu) begin
                cnt     <= 4'(DIV_CYCLES);
                pend_hi <= rem;
                pend_lo <= quot;
            end else if (do_mthi) begin
                hi_q <= bus.a;
            end else if (do_mtlo) begin
                lo_q <= bus.a;
            end
        end
    end

    // Outputs.
    always_comb begin
        bus.busy  = busy_w;
        bus.done  = done_q;
        bus.hi    = hi_q;
        bus.lo    = lo_q;
        dbg_state = state;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Execute-stage multiply/divide unit with architectural HI/LO registers. It consumes the one-hot `mult`, `multu`, `div`, `divu`, `mthi` and `mtlo` strobes produced by the instruction decoder, together with the forwarded rs/rt operands. It runs the fixed-latency operation and exposes `busy` so hazard logic can stall any following HI/LO-class instruction. `mfhi`/`mflo` read the `hi`/`lo` outputs directly.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`; legal range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `mult`, `multu`, `div`, `divu`, `mthi`, `mtlo`  in  1 each  decoded op strobes, E-stage valid.
- `kill`  in  1  exception/interrupt flush; suppresses any op strobe this cycle.
- `a`  in  32  rs operand (dividend / multiplicand / mthi-mtlo source).
- `b`  in  32  rt operand (divisor / multiplier).
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse in the first cycle new results are visible.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- FSM states: IDLE, MUL, DIV. Reset → IDLE.
- Effective strobe is `op & ~kill & ~busy`. Strobes while `busy` are ignored with no effect on state, HI or LO.
- Priority if several strobes are set: `mult` > `multu` > `div` > `divu` > `mthi` > `mtlo`.
- IDLE + mult/multu:
  - the 64-bit product (signed or unsigned per op) is latched into internal pending regs;
  - counter ← `MULT_CYCLES`; → MUL.
- IDLE + div/divu:
  - quotient and remainder are latched into pending regs;
  - counter ← `DIV_CYCLES`; → DIV.
- MUL/DIV:
  - the counter decrements every edge;
  - on the edge where it goes 1→0: HI ← pending[63:32] (product) or remainder; LO ← pending[31:0] or quotient; → IDLE.
- mthi/mtlo (IDLE only): HI (resp. LO) ← `a` at that edge. No busy, no `done`.
- Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero (both signed and unsigned): LO ← 0xFFFFFFFF, HI ← `a`.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO ← 0x80000000, HI ← 0.
- HI/LO keep their old values throughout MUL/DIV. Pending values are never visible early.
- `kill` during MUL/DIV does not abort: an issued op always completes.
- `reset` mid-operation: pending results discarded; → IDLE.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0, state IDLE.
- `busy` = (state != IDLE), registered.
- For an op accepted at edge T, `busy` is high for exactly N cycles (N = `MULT_CYCLES` or `DIV_CYCLES`), starting in the cycle after T.
- New `hi`/`lo` and `done`=1 appear in cycle T+N+1, the first cycle `busy`=0.
- A new op is accepted in that same cycle (back-to-back issue, zero bubble).
- mthi/mtlo: the value is readable on `hi`/`lo` in the cycle after the edge.
- Upstream stall condition is `(busy | any op strobe this cycle) & E-stage instruction is mfttype`. That logic is external; this block only guarantees the `busy` timing above.

## Test plan
- `mult`, a=0xFFFFFFFF, b=2 → `busy` high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE, `done` pulse for 1 cycle. `multu` with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- `div`, a=0xFFFFFFF9 (−7), b=2 → `busy` high for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. `divu`, a=7, b=2 → lo=3, hi=1.
- Corner divisions:
  - `div`, a=0x12345678, b=0 → lo=0xFFFFFFFF, hi=0x12345678;
  - `div`, a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- `mthi` a=0xAAAA0000, then `mtlo` a=0x5555 → hi/lo update one cycle each with `busy`=0. A `mthi` issued while `busy` (mid-`div`) is ignored; the final hi equals the div remainder.
- `mult` with `kill`=1 → no busy, hi/lo unchanged. `kill` asserted at cycle 3 of an active `div` → the div still completes with correct results.
- Assert `reset` at cycle 4 of a `mult` → next cycle `busy`=0, hi=lo=0, no `done`. A `divu` issued the same cycle a prior `mult` completes is accepted, and results arrive 10 cycles later.
